// File: rtl/alu.sv
// alu: registered 32-bit integer ALU for the RV32 execute stage.
// Computes ADD, SUB, AND, OR, XOR, SLL, SRL and signed SLT. The result and the
// V/N/Zero flags are captured in output registers with one-cycle latency.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   A, B       - 32-bit two's complement operands (B[4:0] is the shift amount)
//   ALUControl - operation select
//   Result     - registered result
//   V, N, Zero - registered overflow, negative and zero flags
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUControl,
   output logic [31:0] Result,
   output logic        V,
   output logic        N,
   output logic        Zero
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;
   localparam logic [2:0] OpSll = 3'b101;
   localparam logic [2:0] OpSrl = 3'b110;
   localparam logic [2:0] OpSlt = 3'b111;

   logic        is_sub;
   logic [31:0] b_eff;
   logic [31:0] sum;
   logic        ovf;
   logic [31:0] result_d;
   logic        v_d;

   // One shared adder: SUB and SLT use A + ~B + 1.
   always_comb begin
      is_sub = (ALUControl == OpSub) || (ALUControl == OpSlt);
      b_eff  = is_sub ? ~B : B;
      sum    = A + b_eff + {31'b0, is_sub};
      // Operands of the effective addition share a sign but the sum does not.
      ovf    = (A[31] == b_eff[31]) && (sum[31] != A[31]);
   end

   always_comb begin
      result_d = 32'b0;
      v_d      = 1'b0;
      unique case (ALUControl)
         OpAdd: begin
            result_d = sum;
            v_d      = ovf;
         end
         OpSub: begin
            result_d = sum;
            v_d      = ovf;
         end
         OpAnd: result_d = A & B;
         OpOr:  result_d = A | B;
         OpXor: result_d = A ^ B;
         OpSll: result_d = A << B[4:0];
         OpSrl: result_d = A >> B[4:0];
         // Sign of the difference corrected by overflow gives the true signed compare.
         OpSlt: result_d = {31'b0, sum[31] ^ ovf};
         default: begin
            result_d = 32'b0;
            v_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result <= 32'b0;
         V      <= 1'b0;
         N      <= 1'b0;
         Zero   <= 1'b1;
      end else begin
         Result <= result_d;
         V      <= v_d;
         N      <= result_d[31];
         Zero   <= (result_d == 32'b0);
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu. The driver issues one operation per cycle
// on the falling edge and queues the reference-model expectation; the monitor
// pops one entry after every rising edge and compares all outputs.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUControl;
   logic [31:0] Result;
   logic        V;
   logic        N;
   logic        Zero;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Result     (Result),
      .V          (V),
      .N          (N),
      .Zero       (Zero)
   );

   typedef struct {
      logic [31:0] r;
      logic        v;
      logic        n;
      logic        z;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: signed 64-bit arithmetic, overflow = result out of int32 range.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op);
      exp_t   e;
      longint sa;
      longint sb;
      longint wide;
      int     sh;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      sh   = int'(b & 32'd31);
      e.v  = 1'b0;
      e.r  = 32'b0;
      wide = 0;
      case (op)
         3'd0: begin
            wide = sa + sb;
            e.r  = wide[31:0];
            e.v  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         3'd1: begin
            wide = sa - sb;
            e.r  = wide[31:0];
            e.v  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         3'd2: e.r = a & b;
         3'd3: e.r = a | b;
         3'd4: e.r = a ^ b;
         3'd5: e.r = a << sh;
         3'd6: e.r = a >> sh;
         default: e.r = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      e.n = e.r[31];
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   task automatic issue(input logic rstn, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n      = rstn;
      A          = a;
      B          = b;
      ALUControl = op;
      if (rstn) begin
         e = model(a, b, op);
      end else begin
         e.r = 32'd0;
         e.v = 1'b0;
         e.n = 1'b0;
         e.z = 1'b1;
      end
      e.tag = tag;
      q.push_back(e);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'($urandom_range(0, 3));
         3: return 32'hFFFFFFFF - 32'($urandom_range(0, 2));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: one result per rising edge, sampled 1 ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (Result !== e.r) begin
               errors++;
               $display("FAIL %s Result: got %h expected %h", e.tag, Result, e.r);
            end
            checks++;
            if (V !== e.v) begin
               errors++;
               $display("FAIL %s V: got %b expected %b", e.tag, V, e.v);
            end
            checks++;
            if (N !== e.n) begin
               errors++;
               $display("FAIL %s N: got %b expected %b", e.tag, N, e.n);
            end
            checks++;
            if (Zero !== e.z) begin
               errors++;
               $display("FAIL %s Zero: got %b expected %b", e.tag, Zero, e.z);
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      A          = 32'd0;
      B          = 32'd0;
      ALUControl = 3'd0;

      issue(1'b0, $urandom, $urandom, 3'($urandom), "reset0");
      issue(1'b0, 32'h7FFFFFFF, 32'd1, 3'd0, "reset1");
      issue(1'b1, 32'd124, 32'd73, 3'd0, "rel_add");

      issue(1'b1, 32'd124, -32'sd73, 3'd0, "add_pos_neg");
      issue(1'b1, -32'sd124, -32'sd73, 3'd0, "add_neg_neg");
      issue(1'b1, 32'd20, 32'd120, 3'd1, "sub_neg");
      issue(1'b1, 32'd124, 32'd124, 3'd1, "sub_zero");
      issue(1'b1, -32'sd20, -32'sd120, 3'd1, "sub_pos");

      issue(1'b1, 32'h7FFFFFFF, 32'd1, 3'd0, "add_ovf");
      issue(1'b1, 32'h80000000, 32'd1, 3'd1, "sub_ovf");
      issue(1'b1, 32'd124, 32'd73, 3'd0, "add_no_ovf");

      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd2, "and");
      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd3, "or");
      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd4, "xor");
      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd5, "sll");
      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd6, "srl");
      issue(1'b1, 32'hFFFFFFEC, 32'hFFFFFF88, 3'd7, "slt_false");
      issue(1'b1, 32'h80000000, 32'd1, 3'd7, "slt_ovf");
      issue(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'd7, "slt_ovf_neg");

      // Back-to-back: new operation every cycle.
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, $urandom, $urandom, 3'(i), "b2b");
      end

      // Random traffic with occasional reset pulses overriding the operation.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            issue(1'b0, $urandom, $urandom, 3'($urandom), "rnd_reset");
         end else begin
            issue(1'b1, rnd_operand(), rnd_operand(), 3'($urandom), "rnd");
         end
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending results expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
